// File: rtl/baser_257b_multilane_checker_pkg.sv
// Shared types and block classification for the multi-lane 257b BASE-R checker.
// A 257b transcoded block carries the header in bit 0 and 32 payload bytes in [256:1].
package baser_chk_pkg;

   typedef enum logic {HUNT, LOCKED} lane_state_t;
   typedef enum logic [1:0] {BLK_DATA, BLK_CTRL, BLK_INV} blk_class_t;

   localparam int TC_BITS      = 257;
   localparam int TC_HDR_BIT   = 0;
   localparam int TC_FLAGS_LSB = 1;
   localparam int TC_TYPE_LSB  = 5;

   // Control payload beyond the compressed type nibble is deliberately not inspected.
   function automatic blk_class_t classify(input logic [TC_BITS-1:0] blk, input logic [7:0] pattern);
      blk_class_t cls;
      if (blk[TC_HDR_BIT]) begin
         cls = BLK_DATA;
         for (int b = 0; b < 32; b++)
            if (blk[1+8*b +: 8] != pattern) cls = BLK_INV;
      end else if (blk[TC_FLAGS_LSB +: 4] == 4'hF || blk[TC_TYPE_LSB +: 4] == 4'h0) begin
         cls = BLK_INV;
      end else begin
         cls = BLK_CTRL;
      end
      return cls;
   endfunction

endpackage

// File: rtl/baser_257b_multilane_checker_if.sv
// Block/strobe inputs and per-lane statistics outputs of the multi-lane checker.
interface baser_257b_multilane_checker_if #(
   parameter int N_LANES   = 2,
   parameter int TC_WIDTH  = 257,
   parameter int CNT_WIDTH = 32
);
   logic [N_LANES-1:0]           i_valid;
   logic [N_LANES*TC_WIDTH-1:0]  i_rx_coded;
   logic                         i_clear;
   logic [N_LANES-1:0]           i_relock;
   logic [N_LANES-1:0]           o_lock;
   logic [N_LANES*CNT_WIDTH-1:0] o_block_count;
   logic [N_LANES*CNT_WIDTH-1:0] o_data_count;
   logic [N_LANES*CNT_WIDTH-1:0] o_ctrl_count;
   logic [N_LANES*CNT_WIDTH-1:0] o_inv_count;
   logic [N_LANES*CNT_WIDTH-1:0] o_unlock_count;

   modport master (
      output i_valid, i_rx_coded, i_clear, i_relock,
      input  o_lock, o_block_count, o_data_count, o_ctrl_count, o_inv_count, o_unlock_count
   );

   modport slave (
      input  i_valid, i_rx_coded, i_clear, i_relock,
      output o_lock, o_block_count, o_data_count, o_ctrl_count, o_inv_count, o_unlock_count
   );
endinterface

// File: rtl/baser_257b_multilane_checker_lane.sv
// One checker lane: S1 classifies and registers the block, S2 updates the
// saturating statistics and the HUNT/LOCKED error-window state machine.
module baser_257b_lane_checker
   import baser_chk_pkg::*;
#(
   parameter int         TC_WIDTH     = 257,
   parameter int         CNT_WIDTH    = 32,
   parameter logic [7:0] DATA_PATTERN = 8'hAA,
   parameter int         LOCK_GOOD    = 64,
   parameter int         ERR_WINDOW   = 128,
   parameter int         ERR_THRESH   = 16
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   input  logic                 valid_i,
   input  logic [TC_WIDTH-1:0]  coded_i,
   input  logic                 clear_i,
   input  logic                 relock_i,
   output logic                 lock_o,
   output logic [CNT_WIDTH-1:0] block_cnt_o,
   output logic [CNT_WIDTH-1:0] data_cnt_o,
   output logic [CNT_WIDTH-1:0] ctrl_cnt_o,
   output logic [CNT_WIDTH-1:0] inv_cnt_o,
   output logic [CNT_WIDTH-1:0] unlock_cnt_o
);

   localparam int GR_W  = (LOCK_GOOD > 1)  ? $clog2(LOCK_GOOD)  : 1;
   localparam int WIN_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
   localparam int ERR_W = $clog2(ERR_THRESH + 1);
   localparam logic [GR_W-1:0]  GR_LAST  = GR_W'(LOCK_GOOD - 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ERR_WINDOW - 1);
   localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_THRESH - 1);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic                 s1_vld_q;
   blk_class_t           s1_cls_q;
   lane_state_t          state_q, state_d;
   logic [GR_W-1:0]      run_q, run_d;
   logic [WIN_W-1:0]     win_q, win_d;
   logic [ERR_W-1:0]     err_q, err_d;
   logic [CNT_WIDTH-1:0] blk_q, blk_d, data_q, data_d, ctrl_q, ctrl_d;
   logic [CNT_WIDTH-1:0] inv_q, inv_d, unl_q, unl_d;
   logic                 is_inv, unlock_ev;

   assign is_inv = (s1_cls_q == BLK_INV);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_vld_q <= 1'b0;
         s1_cls_q <= BLK_DATA;
      end else begin
         s1_vld_q <= valid_i;
         s1_cls_q <= classify(coded_i, DATA_PATTERN);
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= HUNT;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_q  <= '0;
         win_q  <= '0;
         err_q  <= '0;
         blk_q  <= '0;
         data_q <= '0;
         ctrl_q <= '0;
         inv_q  <= '0;
         unl_q  <= '0;
      end else begin
         run_q  <= run_d;
         win_q  <= win_d;
         err_q  <= err_d;
         blk_q  <= blk_d;
         data_q <= data_d;
         ctrl_q <= ctrl_d;
         inv_q  <= inv_d;
         unl_q  <= unl_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      win_d     = win_q;
      err_d     = err_q;
      blk_d     = blk_q;
      data_d    = data_q;
      ctrl_d    = ctrl_q;
      inv_d     = inv_q;
      unl_d     = unl_q;
      unlock_ev = 1'b0;

      if (s1_vld_q) begin
         blk_d = sat_inc(blk_q);
         unique case (s1_cls_q)
            BLK_DATA: data_d = sat_inc(data_q);
            BLK_CTRL: ctrl_d = sat_inc(ctrl_q);
            default:  inv_d  = sat_inc(inv_q);
         endcase

         case (state_q)
            HUNT: begin
               if (is_inv) begin
                  run_d = '0;
               end else if (run_q == GR_LAST) begin
                  state_d = LOCKED;
                  run_d   = '0;
                  win_d   = '0;
                  err_d   = '0;
               end else begin
                  run_d = run_q + 1'b1;
               end
            end
            LOCKED: begin
               // Threshold is evaluated before the window wrap on the same block.
               if (is_inv && err_q == ERR_LAST) begin
                  state_d   = HUNT;
                  unlock_ev = 1'b1;
                  run_d     = '0;
                  win_d     = '0;
                  err_d     = '0;
               end else if (win_q == WIN_LAST) begin
                  win_d = '0;
                  err_d = '0;
               end else begin
                  win_d = win_q + 1'b1;
                  if (is_inv) err_d = err_q + 1'b1;
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (relock_i) begin
         state_d   = HUNT;
         run_d     = '0;
         win_d     = '0;
         err_d     = '0;
         unlock_ev = (state_q == LOCKED);
      end

      if (unlock_ev) unl_d = sat_inc(unl_q);

      // Clear only zeroes statistics; lock state keeps evolving.
      if (clear_i) begin
         blk_d  = '0;
         data_d = '0;
         ctrl_d = '0;
         inv_d  = '0;
         unl_d  = '0;
      end
   end

   assign lock_o       = (state_q == LOCKED);
   assign block_cnt_o  = blk_q;
   assign data_cnt_o   = data_q;
   assign ctrl_cnt_o   = ctrl_q;
   assign inv_cnt_o    = inv_q;
   assign unlock_cnt_o = unl_q;

endmodule

// File: rtl/baser_257b_multilane_checker.sv
// N independent 257b BASE-R checker lanes; lane k uses slice k of every bus field.
module baser_257b_multilane_checker
   import baser_chk_pkg::*;
#(
   parameter int         N_LANES      = 2,
   parameter int         TC_WIDTH     = 257,
   parameter int         CNT_WIDTH    = 32,
   parameter logic [7:0] DATA_PATTERN = 8'hAA,
   parameter int         LOCK_GOOD    = 64,
   parameter int         ERR_WINDOW   = 128,
   parameter int         ERR_THRESH   = 16
) (
   input logic                          clk,
   input logic                          i_rst_n,
   baser_257b_multilane_checker_if.slave bus
);

   logic [N_LANES-1:0]                lock;
   logic [N_LANES-1:0][CNT_WIDTH-1:0] blk_cnt, data_cnt, ctrl_cnt, inv_cnt, unl_cnt;

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      baser_257b_lane_checker #(
         .TC_WIDTH     (TC_WIDTH),
         .CNT_WIDTH    (CNT_WIDTH),
         .DATA_PATTERN (DATA_PATTERN),
         .LOCK_GOOD    (LOCK_GOOD),
         .ERR_WINDOW   (ERR_WINDOW),
         .ERR_THRESH   (ERR_THRESH)
      ) u_lane (
         .clk          (clk),
         .i_rst_n      (i_rst_n),
         .valid_i      (bus.i_valid[k]),
         .coded_i      (bus.i_rx_coded[k*TC_WIDTH +: TC_WIDTH]),
         .clear_i      (bus.i_clear),
         .relock_i     (bus.i_relock[k]),
         .lock_o       (lock[k]),
         .block_cnt_o  (blk_cnt[k]),
         .data_cnt_o   (data_cnt[k]),
         .ctrl_cnt_o   (ctrl_cnt[k]),
         .inv_cnt_o    (inv_cnt[k]),
         .unlock_cnt_o (unl_cnt[k])
      );
   end

   assign bus.o_lock         = lock;
   assign bus.o_block_count  = blk_cnt;
   assign bus.o_data_count   = data_cnt;
   assign bus.o_ctrl_count   = ctrl_cnt;
   assign bus.o_inv_count    = inv_cnt;
   assign bus.o_unlock_count = unl_cnt;

endmodule

// File: tb/tb_baser_257b_multilane_checker.sv
// Scoreboard bench: a lane model predicts outputs per drive cycle; a negedge monitor compares them.
module tb_baser_257b_multilane_checker;

   localparam logic [7:0] PAT = 8'hAA;
   localparam int LOCK_GOOD  = 64;
   localparam int ERR_WINDOW = 128;
   localparam int ERR_THRESH = 16;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   baser_257b_multilane_checker_if #(.N_LANES(2), .TC_WIDTH(257), .CNT_WIDTH(32)) bus ();
   baser_257b_multilane_checker_if #(.N_LANES(2), .TC_WIDTH(257), .CNT_WIDTH(4))  bus_s ();

   baser_257b_multilane_checker #(.N_LANES(2), .TC_WIDTH(257), .CNT_WIDTH(32)) dut (
      .clk(clk), .i_rst_n(rst_n), .bus(bus));
   baser_257b_multilane_checker #(.N_LANES(2), .TC_WIDTH(257), .CNT_WIDTH(4)) dut_s (
      .clk(clk), .i_rst_n(rst_n), .bus(bus_s));

   typedef struct {
      int          due;
      logic [1:0]  lock;
      logic [63:0] blk, dat, ctl, inv, unl;
   } exp_t;
   exp_t sbq[$];

   // Lane model: counts 0=block 1=data 2=ctrl 3=inv 4=unlock; class 0=data 1=ctrl 2=inv.
   logic [1:0]  m_lock;
   int          m_run[2], m_win[2], m_err[2], m_s1c[2];
   logic [1:0]  m_s1v;
   logic [31:0] m_cnt[2][5];
   logic [256:0] GOOD_BLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int cls_of(input logic [256:0] b);
      logic [255:0] pl;
      pl = b[256:1];
      if (b[0]) return (pl == {32{PAT}}) ? 0 : 2;
      if (b[4:1] == 4'hF) return 2;
      if (b[8:5] == 4'h0) return 2;
      return 1;
   endfunction

   function automatic logic [256:0] mk_ctrl(input logic [3:0] flags, input logic [3:0] typ);
      logic [256:0] b;
      b = {1'b0, {8{$urandom}}};
      b[0]   = 1'b0;
      b[4:1] = flags;
      b[8:5] = typ;
      return b;
   endfunction

   function automatic logic [256:0] bad_byte5();
      logic [256:0] b;
      b = GOOD_BLK;
      b[41 +: 8] = 8'h55;
      return b;
   endfunction

   task automatic model_reset();
      m_lock = '0;
      m_s1v  = '0;
      for (int k = 0; k < 2; k++) begin
         m_run[k] = 0; m_win[k] = 0; m_err[k] = 0; m_s1c[k] = 0;
         for (int i = 0; i < 5; i++) m_cnt[k][i] = '0;
      end
   endtask

   task automatic bump(input int k, input int i);
      if (m_cnt[k][i] != 32'hFFFF_FFFF) m_cnt[k][i] = m_cnt[k][i] + 1;
   endtask

   task automatic model_edge(input logic [1:0] v, input logic [256:0] b0, input logic [256:0] b1,
                             input logic clr, input logic [1:0] rl);
      logic [256:0] bb[2];
      logic was_locked, unl;
      bb[0] = b0;
      bb[1] = b1;
      for (int k = 0; k < 2; k++) begin
         was_locked = m_lock[k];
         unl = 1'b0;
         if (m_s1v[k]) begin
            bump(k, 0);
            bump(k, 1 + m_s1c[k]);
            if (!m_lock[k]) begin
               m_run[k] = (m_s1c[k] == 2) ? 0 : m_run[k] + 1;
               if (m_run[k] == LOCK_GOOD) begin
                  m_lock[k] = 1'b1; m_run[k] = 0; m_win[k] = 0; m_err[k] = 0;
               end
            end else begin
               m_win[k] = m_win[k] + 1;
               if (m_s1c[k] == 2) m_err[k] = m_err[k] + 1;
               if (m_err[k] == ERR_THRESH) begin
                  m_lock[k] = 1'b0; unl = 1'b1; m_run[k] = 0; m_win[k] = 0; m_err[k] = 0;
               end else if (m_win[k] == ERR_WINDOW) begin
                  m_win[k] = 0; m_err[k] = 0;
               end
            end
         end
         if (rl[k]) begin
            unl = was_locked;
            m_lock[k] = 1'b0; m_run[k] = 0; m_win[k] = 0; m_err[k] = 0;
         end
         if (unl) bump(k, 4);
         if (clr) for (int i = 0; i < 5; i++) m_cnt[k][i] = '0;
         m_s1v[k] = v[k];
         m_s1c[k] = cls_of(bb[k]);
      end
   endtask

   task automatic step(input logic [1:0] v, input logic [256:0] b0, input logic [256:0] b1,
                       input logic clr, input logic [1:0] rl);
      exp_t e;
      @(posedge clk); #1;
      bus.i_valid    = v;
      bus.i_rx_coded = {b1, b0};
      bus.i_clear    = clr;
      bus.i_relock   = rl;
      model_edge(v, b0, b1, clr, rl);
      e.due  = cyc + 1;
      e.lock = m_lock;
      e.blk  = {m_cnt[1][0], m_cnt[0][0]};
      e.dat  = {m_cnt[1][1], m_cnt[0][1]};
      e.ctl  = {m_cnt[1][2], m_cnt[0][2]};
      e.inv  = {m_cnt[1][3], m_cnt[0][3]};
      e.unl  = {m_cnt[1][4], m_cnt[0][4]};
      sbq.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, GOOD_BLK, GOOD_BLK, 1'b0, 2'b00);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         chk("sb_lock",   {62'd0, bus.o_lock}, {62'd0, e.lock});
         chk("sb_block",  bus.o_block_count,  e.blk);
         chk("sb_data",   bus.o_data_count,   e.dat);
         chk("sb_ctrl",   bus.o_ctrl_count,   e.ctl);
         chk("sb_inv",    bus.o_inv_count,    e.inv);
         chk("sb_unlock", bus.o_unlock_count, e.unl);
      end
   end

   initial begin
      logic [256:0] b0, b1;
      logic [1:0]   v, rl;
      GOOD_BLK = {{32{PAT}}, 1'b1};
      rst_n = 1'b0;
      bus.i_valid = '0; bus.i_rx_coded = '0; bus.i_clear = 1'b0; bus.i_relock = '0;
      bus_s.i_valid = '0; bus_s.i_rx_coded = '0; bus_s.i_clear = 1'b0; bus_s.i_relock = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset and idle
      idle(10);
      @(negedge clk);
      chk("rst_lock",  {62'd0, bus.o_lock}, 64'd0);
      chk("rst_block", bus.o_block_count, 64'd0);
      chk("rst_inv",   bus.o_inv_count, 64'd0);

      // lane0 lock after 64 good data blocks
      for (int i = 0; i < 64; i++) step(2'b01, GOOD_BLK, GOOD_BLK, 1'b0, 2'b00);
      idle(1);
      @(negedge clk);
      chk("lock0_early", {63'd0, bus.o_lock[0]}, 64'd0);
      idle(1);
      @(negedge clk);
      chk("lock0",      {63'd0, bus.o_lock[0]}, 64'd1);
      chk("lock0_data", bus.o_data_count[31:0], 64'd64);
      chk("lane1_blk",  bus.o_block_count[63:32], 64'd0);

      // classification on lane1
      step(2'b10, GOOD_BLK, mk_ctrl(4'hE, 4'h1), 1'b0, 2'b00);
      step(2'b10, GOOD_BLK, mk_ctrl(4'hF, 4'h1), 1'b0, 2'b00);
      step(2'b10, GOOD_BLK, mk_ctrl(4'hE, 4'h0), 1'b0, 2'b00);
      step(2'b10, GOOD_BLK, bad_byte5(), 1'b0, 2'b00);
      idle(2);
      @(negedge clk);
      chk("cls_ctrl",  bus.o_ctrl_count[63:32], 64'd1);
      chk("cls_inv",   bus.o_inv_count[63:32], 64'd3);
      chk("cls_block", bus.o_block_count[63:32], 64'd4);

      // lane0: 15 invalid per 128-block window, three windows, stays locked
      for (int w = 0; w < 3; w++)
         for (int i = 0; i < 128; i++)
            step(2'b01, (i % 8 == 3 && i < 120) ? mk_ctrl(4'hF, 4'h2) : GOOD_BLK,
                 GOOD_BLK, 1'b0, 2'b00);
      idle(2);
      @(negedge clk);
      chk("win15_lock", {63'd0, bus.o_lock[0]}, 64'd1);
      chk("win15_unl",  bus.o_unlock_count[31:0], 64'd0);

      // lane0: 16 invalid within one window unlocks
      for (int i = 0; i < 16; i++) step(2'b01, mk_ctrl(4'h3, 4'h0), GOOD_BLK, 1'b0, 2'b00);
      idle(2);
      @(negedge clk);
      chk("unl_lock", {63'd0, bus.o_lock[0]}, 64'd0);
      chk("unl_cnt",  bus.o_unlock_count[31:0], 64'd1);

      // lane1 lock then forced relock
      for (int i = 0; i < 64; i++) step(2'b10, GOOD_BLK, GOOD_BLK, 1'b0, 2'b00);
      idle(2);
      @(negedge clk);
      chk("lock1", {63'd0, bus.o_lock[1]}, 64'd1);
      step(2'b00, GOOD_BLK, GOOD_BLK, 1'b0, 2'b10);
      idle(1);
      @(negedge clk);
      chk("relock_lock", {63'd0, bus.o_lock[1]}, 64'd0);
      chk("relock_unl",  bus.o_unlock_count[63:32], 64'd1);

      // mixed traffic on both lanes with occasional relock and one clear
      for (int i = 0; i < 60; i++) begin
         v  = 2'($urandom_range(0, 3));
         b0 = ($urandom_range(0, 9) == 0) ? mk_ctrl(4'hF, 4'h5) :
              ($urandom_range(0, 9) == 0) ? mk_ctrl(4'h7, 4'h9) : GOOD_BLK;
         b1 = ($urandom_range(0, 9) == 0) ? bad_byte5() :
              ($urandom_range(0, 9) == 0) ? mk_ctrl(4'h0, 4'hC) : GOOD_BLK;
         rl = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         step(v, b0, b1, (i == 30), rl);
      end
      idle(2);

      // saturation and clear on the 4-bit counter instance
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         bus_s.i_valid = 2'b01; bus_s.i_rx_coded = {GOOD_BLK, GOOD_BLK};
      end
      @(posedge clk); #1 bus_s.i_valid = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("sat_block", {60'd0, bus_s.o_block_count[3:0]}, 64'hF);
      chk("sat_data",  {60'd0, bus_s.o_data_count[3:0]}, 64'hF);
      chk("sat_lane1", {60'd0, bus_s.o_block_count[7:4]}, 64'd0);
      @(posedge clk); #1 bus_s.i_valid = 2'b01;
      @(posedge clk); #1 bus_s.i_clear = 1'b1;
      @(posedge clk); #1 begin bus_s.i_clear = 1'b0; bus_s.i_valid = 2'b00; end
      @(negedge clk);
      chk("clr_block", {60'd0, bus_s.o_block_count[3:0]}, 64'd0);
      chk("clr_data",  {60'd0, bus_s.o_data_count[3:0]}, 64'd0);
      @(negedge clk);
      chk("clr_s1_flow", {60'd0, bus_s.o_block_count[3:0]}, 64'd1);

      // lock both lanes, then asynchronous reset mid-stream
      for (int i = 0; i < 64; i++) step(2'b11, GOOD_BLK, GOOD_BLK, 1'b0, 2'b00);
      idle(2);
      @(negedge clk);
      chk("pre_arst_lock", {62'd0, bus.o_lock}, 64'd3);
      step(2'b11, GOOD_BLK, GOOD_BLK, 1'b0, 2'b00);
      #2 rst_n = 1'b0;
      sbq.delete();
      model_reset();
      #1;
      chk("arst_lock",  {62'd0, bus.o_lock}, 64'd0);
      chk("arst_block", bus.o_block_count, 64'd0);
      chk("arst_data",  bus.o_data_count, 64'd0);
      chk("arst_unl",   bus.o_unlock_count, 64'd0);
      chk("arst_small", {56'd0, bus_s.o_block_count}, 64'd0);
      bus.i_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(3);
      repeat (2) @(posedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
